// File: rtl/dino_pkg.sv
// Shared types and default physics constants for the dinosaur jump blocks.
package dino_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } jump_state_t;

  localparam int DEF_HEIGHT_W = 8;
  localparam int DEF_VEL_W    = 6;
  localparam int DEF_JUMP_VEL = 5;
  localparam int DEF_GRAVITY  = 1;
  localparam int DEF_MAX_FALL = 15;

endpackage

// File: rtl/dino_edge_detect.sv
// Rising-edge detector for an already-synchronised button level.
module dino_edge_detect (
  input  logic CLK,
  input  logic RST,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge CLK) begin
    if (RST) level_q <= 1'b0;
    else     level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/jump_physics.sv
// Tick-driven jump/fall physics for the dinosaur sprite.
// Optional double jump: define JUMP_PHYSICS_DOUBLE_JUMP_EN.
module jump_physics
  import dino_pkg::*;
#(
  parameter int HEIGHT_W = DEF_HEIGHT_W,
  parameter int VEL_W    = DEF_VEL_W,
  parameter int JUMP_VEL = DEF_JUMP_VEL,
  parameter int GRAVITY  = DEF_GRAVITY,
  parameter int MAX_FALL = DEF_MAX_FALL
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                tick,
  input  logic                button_jump,
  input  logic                game_status,
  output logic [HEIGHT_W-1:0] dinosaur_height,
  output logic                airborne,
  output logic                landed
);

  if (JUMP_VEL >= (1 << VEL_W) || MAX_FALL >= (1 << VEL_W) || GRAVITY == 0) begin : g_param_check
    $error("jump_physics: illegal JUMP_VEL/MAX_FALL/GRAVITY for VEL_W");
  end

  localparam int SW = ((HEIGHT_W > VEL_W) ? HEIGHT_W : VEL_W) + 1;
  localparam logic [SW-1:0]    HMAX = {{(SW-HEIGHT_W){1'b0}}, {HEIGHT_W{1'b1}}};
  localparam logic [VEL_W-1:0] JV   = VEL_W'(JUMP_VEL);
  localparam logic [VEL_W-1:0] GV   = VEL_W'(GRAVITY);
  localparam logic [VEL_W-1:0] MF   = VEL_W'(MAX_FALL);

  jump_state_t         state_q, state_d;
  logic [HEIGHT_W-1:0] height_q, height_d;
  logic [VEL_W-1:0]    vel_q, vel_d;
  logic [VEL_W-1:0]    fall_q, fall_d;
  logic                req_q, req_d;
  logic                landed_q, landed_d;
`ifdef JUMP_PHYSICS_DOUBLE_JUMP_EN
  logic                dbl_q, dbl_d;
`endif

  logic                press;
  logic                go;
  logic [SW-1:0]       h_ext, rise_sum;
  logic [VEL_W:0]      f_sum;
  logic [VEL_W-1:0]    f_new;

  dino_edge_detect u_btn_edge (
    .CLK  (CLK),
    .RST  (RST),
    .level(button_jump),
    .rise (press)
  );

  function automatic logic [HEIGHT_W-1:0] sat_h(input logic [SW-1:0] v);
    return (v > HMAX) ? HMAX[HEIGHT_W-1:0] : v[HEIGHT_W-1:0];
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= GROUND;
      height_q <= '0;
      vel_q    <= '0;
      fall_q   <= '0;
      req_q    <= 1'b0;
      landed_q <= 1'b0;
`ifdef JUMP_PHYSICS_DOUBLE_JUMP_EN
      dbl_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      height_q <= height_d;
      vel_q    <= vel_d;
      fall_q   <= fall_d;
      req_q    <= req_d;
      landed_q <= landed_d;
`ifdef JUMP_PHYSICS_DOUBLE_JUMP_EN
      dbl_q    <= dbl_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    height_d = height_q;
    vel_d    = vel_q;
    fall_d   = fall_q;
    req_d    = req_q;
    landed_d = 1'b0;
`ifdef JUMP_PHYSICS_DOUBLE_JUMP_EN
    dbl_d    = dbl_q;
`endif
    // A press landing on the same cycle as a tick is consumed by that tick.
    go       = req_q | press;
    h_ext    = SW'(height_q);
    rise_sum = h_ext + SW'(vel_q);
    f_sum    = {1'b0, fall_q} + {1'b0, GV};
    f_new    = (f_sum > {1'b0, MF}) ? MF : f_sum[VEL_W-1:0];

    if (game_status) begin
      if (tick) begin
        req_d = 1'b0;
        unique case (state_q)
          GROUND: if (go) begin
            height_d = sat_h(SW'(JV));
            vel_d    = (JV > GV) ? JV - GV : '0;
            state_d  = RISE;
          end
          RISE: begin
            height_d = sat_h(rise_sum);
            vel_d    = (vel_q > GV) ? vel_q - GV : '0;
            if (vel_q <= GV) begin
              state_d = FALL;
              fall_d  = '0;
            end
          end
          FALL: begin
            fall_d = f_new;
            if (h_ext <= SW'(f_new)) begin
              height_d = '0;
              state_d  = GROUND;
              landed_d = 1'b1;
`ifdef JUMP_PHYSICS_DOUBLE_JUMP_EN
              dbl_d    = 1'b0;
`endif
            end else begin
              height_d = height_q - HEIGHT_W'(f_new);
            end
          end
          default: state_d = GROUND;
        endcase
`ifdef JUMP_PHYSICS_DOUBLE_JUMP_EN
        // Mid-air relaunch behaves like a rise step taken with vel = JUMP_VEL.
        if (state_q != GROUND && go && !dbl_q) begin
          height_d = sat_h(h_ext + SW'(JV));
          vel_d    = (JV > GV) ? JV - GV : '0;
          fall_d   = '0;
          state_d  = RISE;
          landed_d = 1'b0;
          dbl_d    = 1'b1;
        end
`endif
      end else if (press) begin
        req_d = 1'b1;
      end
    end
  end

  assign dinosaur_height = height_q;
  assign airborne        = (state_q != GROUND);
  assign landed          = landed_q;

endmodule
